// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: ALU ops, memory/control ops,
// exception codes and the active-low enable levels.
package ex_stage_pkg;

  localparam logic [3:0] ALU_OP_NOP  = 4'd0;
  localparam logic [3:0] ALU_OP_AND  = 4'd1;
  localparam logic [3:0] ALU_OP_OR   = 4'd2;
  localparam logic [3:0] ALU_OP_XOR  = 4'd3;
  localparam logic [3:0] ALU_OP_ADDS = 4'd4;
  localparam logic [3:0] ALU_OP_ADDU = 4'd5;
  localparam logic [3:0] ALU_OP_SUBS = 4'd6;
  localparam logic [3:0] ALU_OP_SUBU = 4'd7;
  localparam logic [3:0] ALU_OP_SHRL = 4'd8;
  localparam logic [3:0] ALU_OP_SHLL = 4'd9;

  localparam logic [1:0] MEM_OP_NOP = 2'd0;
  localparam logic [1:0] MEM_OP_LDW = 2'd1;
  localparam logic [1:0] MEM_OP_STW = 2'd2;

  localparam logic [1:0] CTRL_OP_NOP  = 2'd0;
  localparam logic [1:0] CTRL_OP_WRCR = 2'd1;
  localparam logic [1:0] CTRL_OP_EXRT = 2'd2;

  localparam logic [2:0] ISA_EXP_NO_EXP     = 3'd0;
  localparam logic [2:0] ISA_EXP_EXT_INT    = 3'd1;
  localparam logic [2:0] ISA_EXP_UNDEF_INSN = 3'd2;
  localparam logic [2:0] ISA_EXP_OVERFLOW   = 3'd3;
  localparam logic [2:0] ISA_EXP_MISS_ALIGN = 3'd4;
  localparam logic [2:0] ISA_EXP_TRAP       = 3'd5;
  localparam logic [2:0] ISA_EXP_PRV_VIO    = 3'd6;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU with signed-overflow detection for ADDS/SUBS only.
module ex_stage_alu
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] in_0_i,
  input  logic [DATA_W-1:0] in_1_i,
  output logic [DATA_W-1:0] out_o,
  output logic              overflow_o
);

  localparam int SHAMT_W = $clog2(DATA_W);
  localparam int MSB     = DATA_W - 1;

  logic [SHAMT_W-1:0] shamt;
  assign shamt = in_1_i[SHAMT_W-1:0];

  always_comb begin
    out_o = '0;
    unique case (op_i)
      ALU_OP_NOP:                out_o = in_0_i;
      ALU_OP_AND:                out_o = in_0_i & in_1_i;
      ALU_OP_OR:                 out_o = in_0_i | in_1_i;
      ALU_OP_XOR:                out_o = in_0_i ^ in_1_i;
      ALU_OP_ADDS, ALU_OP_ADDU:  out_o = in_0_i + in_1_i;
      ALU_OP_SUBS, ALU_OP_SUBU:  out_o = in_0_i - in_1_i;
      ALU_OP_SHRL:               out_o = in_0_i >> shamt;
      ALU_OP_SHLL:               out_o = in_0_i << shamt;
      default:                   out_o = '0;
    endcase
  end

  // Overflow is judged on sign bits only; unsigned variants never trap.
  always_comb begin
    overflow_o = 1'b0;
    if (op_i == ALU_OP_ADDS) begin
      overflow_o = (in_0_i[MSB] == in_1_i[MSB]) && (out_o[MSB] != in_0_i[MSB]);
    end else if (op_i == ALU_OP_SUBS) begin
      overflow_o = (in_0_i[MSB] != in_1_i[MSB]) && (out_o[MSB] != in_0_i[MSB]);
    end
  end

endmodule

// File: rtl/ex_stage_ex_reg.sv
// EX/MEM pipeline register: resolves the exception code and squashes side
// effects (memory, control, GPR write) of excepting or invalid entries.
module ex_stage_ex_reg
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 30,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              int_detect_i,
  input  logic [DATA_W-1:0] alu_out_i,
  input  logic              overflow_i,
  input  logic [PC_W-1:0]   id_pc_i,
  input  logic              id_en_i,
  input  logic              id_br_flag_i,
  input  logic [1:0]        id_mem_op_i,
  input  logic [DATA_W-1:0] id_mem_wr_data_i,
  input  logic [1:0]        id_ctrl_op_i,
  input  logic [REG_AW-1:0] id_dst_addr_i,
  input  logic              id_gpr_we_i,
  input  logic [2:0]        id_exp_code_i,
  output logic [PC_W-1:0]   ex_pc_o,
  output logic              ex_en_o,
  output logic              ex_br_flag_o,
  output logic [1:0]        ex_mem_op_o,
  output logic [DATA_W-1:0] ex_mem_wr_data_o,
  output logic [1:0]        ex_ctrl_op_o,
  output logic [REG_AW-1:0] ex_dst_addr_o,
  output logic              ex_gpr_we_o,
  output logic [2:0]        ex_exp_code_o,
  output logic [DATA_W-1:0] ex_out_o
);

  logic [PC_W-1:0]   pc_q, pc_d;
  logic              en_q, en_d;
  logic              br_flag_q, br_flag_d;
  logic [1:0]        mem_op_q, mem_op_d;
  logic [DATA_W-1:0] mem_wr_data_q, mem_wr_data_d;
  logic [1:0]        ctrl_op_q, ctrl_op_d;
  logic [REG_AW-1:0] dst_addr_q, dst_addr_d;
  logic              gpr_we_q, gpr_we_d;
  logic [2:0]        exp_code_q, exp_code_d;
  logic [DATA_W-1:0] out_q, out_d;

  logic [2:0] exp_res;
  logic       squash;

  always_comb begin
    exp_res = ISA_EXP_NO_EXP;
    if (id_en_i) begin
      if (int_detect_i)                         exp_res = ISA_EXP_EXT_INT;
      else if (id_exp_code_i != ISA_EXP_NO_EXP) exp_res = id_exp_code_i;
      else if (overflow_i)                      exp_res = ISA_EXP_OVERFLOW;
    end
  end

  assign squash = !id_en_i || (exp_res != ISA_EXP_NO_EXP);

  // Update order: reset > stall (hold everything) > flush (bubble) > load.
  always_comb begin
    pc_d          = pc_q;
    en_d          = en_q;
    br_flag_d     = br_flag_q;
    mem_op_d      = mem_op_q;
    mem_wr_data_d = mem_wr_data_q;
    ctrl_op_d     = ctrl_op_q;
    dst_addr_d    = dst_addr_q;
    gpr_we_d      = gpr_we_q;
    exp_code_d    = exp_code_q;
    out_d         = out_q;
    if (reset_i || (!stall_i && flush_i)) begin
      pc_d          = '0;
      en_d          = 1'b0;
      br_flag_d     = 1'b0;
      mem_op_d      = MEM_OP_NOP;
      mem_wr_data_d = '0;
      ctrl_op_d     = CTRL_OP_NOP;
      dst_addr_d    = '0;
      gpr_we_d      = DISABLE_;
      exp_code_d    = ISA_EXP_NO_EXP;
      out_d         = '0;
    end else if (!stall_i) begin
      pc_d          = id_pc_i;
      en_d          = id_en_i;
      br_flag_d     = id_br_flag_i;
      mem_wr_data_d = id_mem_wr_data_i;
      dst_addr_d    = id_dst_addr_i;
      out_d         = alu_out_i;
      exp_code_d    = exp_res;
      mem_op_d      = squash ? MEM_OP_NOP  : id_mem_op_i;
      ctrl_op_d     = squash ? CTRL_OP_NOP : id_ctrl_op_i;
      gpr_we_d      = squash ? DISABLE_    : id_gpr_we_i;
    end
  end

  always_ff @(posedge clk_i) begin
    pc_q          <= pc_d;
    en_q          <= en_d;
    br_flag_q     <= br_flag_d;
    mem_op_q      <= mem_op_d;
    mem_wr_data_q <= mem_wr_data_d;
    ctrl_op_q     <= ctrl_op_d;
    dst_addr_q    <= dst_addr_d;
    gpr_we_q      <= gpr_we_d;
    exp_code_q    <= exp_code_d;
    out_q         <= out_d;
  end

  assign ex_pc_o          = pc_q;
  assign ex_en_o          = en_q;
  assign ex_br_flag_o     = br_flag_q;
  assign ex_mem_op_o      = mem_op_q;
  assign ex_mem_wr_data_o = mem_wr_data_q;
  assign ex_ctrl_op_o     = ctrl_op_q;
  assign ex_dst_addr_o    = dst_addr_q;
  assign ex_gpr_we_o      = gpr_we_q;
  assign ex_exp_code_o    = exp_code_q;
  assign ex_out_o         = out_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage top: ALU result is forwarded to decode combinationally and
// registered into EX/MEM one cycle later.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 30,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              int_detect,
  input  logic [PC_W-1:0]   id_pc,
  input  logic              id_en,
  input  logic [3:0]        id_alu_op,
  input  logic [DATA_W-1:0] id_alu_in_0,
  input  logic [DATA_W-1:0] id_alu_in_1,
  input  logic              id_br_flag,
  input  logic [1:0]        id_mem_op,
  input  logic [DATA_W-1:0] id_mem_wr_data,
  input  logic [1:0]        id_ctrl_op,
  input  logic [REG_AW-1:0] id_dst_addr,
  input  logic              id_gpr_we_,
  input  logic [2:0]        id_exp_code,
  output logic [DATA_W-1:0] fwd_data,
  output logic [PC_W-1:0]   ex_pc,
  output logic              ex_en,
  output logic              ex_br_flag,
  output logic [1:0]        ex_mem_op,
  output logic [DATA_W-1:0] ex_mem_wr_data,
  output logic [1:0]        ex_ctrl_op,
  output logic [REG_AW-1:0] ex_dst_addr,
  output logic              ex_gpr_we_,
  output logic [2:0]        ex_exp_code,
  output logic [DATA_W-1:0] ex_out
);

  logic [DATA_W-1:0] alu_out;
  logic              alu_overflow;

  ex_stage_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i       (id_alu_op),
    .in_0_i     (id_alu_in_0),
    .in_1_i     (id_alu_in_1),
    .out_o      (alu_out),
    .overflow_o (alu_overflow)
  );

  assign fwd_data = alu_out;

  ex_stage_ex_reg #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_AW(REG_AW)) u_ex_reg (
    .clk_i            (clk),
    .reset_i          (reset),
    .stall_i          (stall),
    .flush_i          (flush),
    .int_detect_i     (int_detect),
    .alu_out_i        (alu_out),
    .overflow_i       (alu_overflow),
    .id_pc_i          (id_pc),
    .id_en_i          (id_en),
    .id_br_flag_i     (id_br_flag),
    .id_mem_op_i      (id_mem_op),
    .id_mem_wr_data_i (id_mem_wr_data),
    .id_ctrl_op_i     (id_ctrl_op),
    .id_dst_addr_i    (id_dst_addr),
    .id_gpr_we_i      (id_gpr_we_),
    .id_exp_code_i    (id_exp_code),
    .ex_pc_o          (ex_pc),
    .ex_en_o          (ex_en),
    .ex_br_flag_o     (ex_br_flag),
    .ex_mem_op_o      (ex_mem_op),
    .ex_mem_wr_data_o (ex_mem_wr_data),
    .ex_ctrl_op_o     (ex_ctrl_op),
    .ex_dst_addr_o    (ex_dst_addr),
    .ex_gpr_we_o      (ex_gpr_we_),
    .ex_exp_code_o    (ex_exp_code),
    .ex_out_o         (ex_out)
  );

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU vectors on fwd_data, EX/MEM capture,
// exception gating, stall/flush priority and mid-stream reset.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, flush, int_detect;
  logic [29:0] id_pc;
  logic        id_en;
  logic [3:0]  id_alu_op;
  logic [31:0] id_alu_in_0, id_alu_in_1;
  logic        id_br_flag;
  logic [1:0]  id_mem_op;
  logic [31:0] id_mem_wr_data;
  logic [1:0]  id_ctrl_op;
  logic [4:0]  id_dst_addr;
  logic        id_gpr_we_;
  logic [2:0]  id_exp_code;
  logic [31:0] fwd_data;
  logic [29:0] ex_pc;
  logic        ex_en, ex_br_flag;
  logic [1:0]  ex_mem_op, ex_ctrl_op;
  logic [31:0] ex_mem_wr_data, ex_out;
  logic [4:0]  ex_dst_addr;
  logic        ex_gpr_we_;
  logic [2:0]  ex_exp_code;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  ex_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .int_detect(int_detect),
    .id_pc(id_pc), .id_en(id_en), .id_alu_op(id_alu_op),
    .id_alu_in_0(id_alu_in_0), .id_alu_in_1(id_alu_in_1),
    .id_br_flag(id_br_flag), .id_mem_op(id_mem_op), .id_mem_wr_data(id_mem_wr_data),
    .id_ctrl_op(id_ctrl_op), .id_dst_addr(id_dst_addr), .id_gpr_we_(id_gpr_we_),
    .id_exp_code(id_exp_code), .fwd_data(fwd_data), .ex_pc(ex_pc), .ex_en(ex_en),
    .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op), .ex_mem_wr_data(ex_mem_wr_data),
    .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr), .ex_gpr_we_(ex_gpr_we_),
    .ex_exp_code(ex_exp_code), .ex_out(ex_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge and are stable for the next one.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    stall = 1'b0; flush = 1'b0; int_detect = 1'b0;
    id_pc = '0; id_en = 1'b0; id_alu_op = ALU_OP_NOP;
    id_alu_in_0 = '0; id_alu_in_1 = '0; id_br_flag = 1'b0;
    id_mem_op = MEM_OP_NOP; id_mem_wr_data = '0; id_ctrl_op = CTRL_OP_NOP;
    id_dst_addr = '0; id_gpr_we_ = DISABLE_; id_exp_code = ISA_EXP_NO_EXP;
  endtask

  task automatic drive_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_out);
    id_alu_op = op; id_alu_in_0 = a; id_alu_in_1 = b;
    exp_q.push_back(exp_out);
  endtask

  // Scoreboard: ex_out after a load must equal the value queued at drive time.
  task automatic check_ex_out(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, ex_out, e);
    end
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_pc"},    {2'b0, ex_pc}, 32'd0);
    check({tag, "_en"},    {31'b0, ex_en}, 32'd0);
    check({tag, "_br"},    {31'b0, ex_br_flag}, 32'd0);
    check({tag, "_mem"},   {30'b0, ex_mem_op}, 32'd0);
    check({tag, "_wdata"}, ex_mem_wr_data, 32'd0);
    check({tag, "_ctrl"},  {30'b0, ex_ctrl_op}, 32'd0);
    check({tag, "_dst"},   {27'b0, ex_dst_addr}, 32'd0);
    check({tag, "_we"},    {31'b0, ex_gpr_we_}, 32'd1);
    check({tag, "_exp"},   {29'b0, ex_exp_code}, 32'd0);
    check({tag, "_out"},   ex_out, 32'd0);
  endtask

  logic [3:0]  vec_op[10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd9, 4'd10, 4'd15};
  logic [31:0] vec_a[10]  = '{32'h12345678, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFF0000, 32'd5,
                              32'h80000000, 32'h1, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] vec_b[10]  = '{32'hDEADBEEF, 32'hFF00FF00, 32'h0F0F0000, 32'h0F0F0F0F, 32'd7,
                              32'h0000003F, 32'h20, 32'h1F, 32'h1, 32'h1};
  logic [31:0] vec_e[10]  = '{32'h12345678, 32'hF000F000, 32'hFFFFF0F0, 32'hF0F00F0F, 32'hFFFFFFFE,
                              32'h1, 32'h1, 32'h80000000, 32'h0, 32'h0};

  initial begin
    drive_idle();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    check_bubble("reset");

    // Combinational ALU table on the forwarding path.
    for (int i = 0; i < 10; i++) begin
      id_alu_op = vec_op[i]; id_alu_in_0 = vec_a[i]; id_alu_in_1 = vec_b[i];
      #1;
      check($sformatf("alu_vec%0d", i), fwd_data, vec_e[i]);
    end

    // ADDU wraps, no overflow, GPR write copied.
    drive_idle();
    id_en = 1'b1; id_gpr_we_ = ENABLE_; id_pc = 30'h100; id_dst_addr = 5'd3;
    drive_alu(ALU_OP_ADDU, 32'hFFFFFFFF, 32'h1, 32'h0);
    #1;
    check("addu_fwd", fwd_data, 32'h0);
    step();
    check_ex_out("addu_out");
    check("addu_exp", {29'b0, ex_exp_code}, ISA_EXP_NO_EXP);
    check("addu_we",  {31'b0, ex_gpr_we_}, 32'd0);
    check("addu_en",  {31'b0, ex_en}, 32'd1);
    check("addu_pc",  {2'b0, ex_pc}, 32'h100);
    check("addu_dst", {27'b0, ex_dst_addr}, 32'd3);

    // ADDS overflow squashes the store and the GPR write.
    id_mem_op = MEM_OP_STW; id_pc = 30'h101;
    drive_alu(ALU_OP_ADDS, 32'h7FFFFFFF, 32'h1, 32'h80000000);
    step();
    check_ex_out("adds_out");
    check("adds_exp", {29'b0, ex_exp_code}, ISA_EXP_OVERFLOW);
    check("adds_we",  {31'b0, ex_gpr_we_}, 32'd1);
    check("adds_mem", {30'b0, ex_mem_op}, MEM_OP_NOP);
    check("adds_en",  {31'b0, ex_en}, 32'd1);
    check("adds_pc",  {2'b0, ex_pc}, 32'h101);

    // SUBS overflow vs SUBU on the same operands.
    id_mem_op = MEM_OP_NOP;
    drive_alu(ALU_OP_SUBS, 32'h80000000, 32'h1, 32'h7FFFFFFF);
    step();
    check_ex_out("subs_out");
    check("subs_exp", {29'b0, ex_exp_code}, ISA_EXP_OVERFLOW);
    drive_alu(ALU_OP_SUBU, 32'h80000000, 32'h1, 32'h7FFFFFFF);
    step();
    check_ex_out("subu_out");
    check("subu_exp", {29'b0, ex_exp_code}, ISA_EXP_NO_EXP);
    check("subu_we",  {31'b0, ex_gpr_we_}, 32'd0);

    // Decode exception outranks ALU overflow.
    id_exp_code = ISA_EXP_TRAP;
    drive_alu(ALU_OP_ADDS, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE);
    step();
    check_ex_out("trap_out");
    check("trap_exp", {29'b0, ex_exp_code}, ISA_EXP_TRAP);
    id_exp_code = ISA_EXP_NO_EXP;

    // SHLL uses only the low 5 bits of the shift amount.
    drive_alu(ALU_OP_SHLL, 32'h1, 32'h24, 32'h10);
    step();
    check_ex_out("shll_out");

    // Known value, then stall, stall+flush, flush.
    id_pc = 30'h10; id_br_flag = 1'b1; id_mem_wr_data = 32'hCAFE0001;
    drive_alu(ALU_OP_XOR, 32'h0000F0F0, 32'h00000FF0, 32'h0000FF00);
    step();
    check_ex_out("xor_out");
    stall = 1'b1; id_pc = 30'h20; id_br_flag = 1'b0;
    id_alu_op = ALU_OP_AND; id_alu_in_0 = 32'h1; id_alu_in_1 = 32'h3;
    step();
    check("stall_out", ex_out, 32'h0000FF00);
    check("stall_pc",  {2'b0, ex_pc}, 32'h10);
    check("stall_br",  {31'b0, ex_br_flag}, 32'd1);
    flush = 1'b1;
    step();
    check("stflush_out", ex_out, 32'h0000FF00);
    check("stflush_en",  {31'b0, ex_en}, 32'd1);
    check("stflush_wd",  ex_mem_wr_data, 32'hCAFE0001);
    stall = 1'b0;
    step();
    check_bubble("flush");
    flush = 1'b0;

    // External interrupt beats decode exception; invalid entry reports none.
    drive_idle();
    id_en = 1'b1; int_detect = 1'b1; id_exp_code = ISA_EXP_UNDEF_INSN;
    id_mem_op = MEM_OP_LDW; id_ctrl_op = CTRL_OP_WRCR; id_gpr_we_ = ENABLE_;
    step();
    check("int_exp",  {29'b0, ex_exp_code}, ISA_EXP_EXT_INT);
    check("int_mem",  {30'b0, ex_mem_op}, MEM_OP_NOP);
    check("int_ctrl", {30'b0, ex_ctrl_op}, CTRL_OP_NOP);
    check("int_we",   {31'b0, ex_gpr_we_}, 32'd1);
    id_en = 1'b0;
    step();
    check("inv_exp",  {29'b0, ex_exp_code}, ISA_EXP_NO_EXP);
    check("inv_en",   {31'b0, ex_en}, 32'd0);
    check("inv_we",   {31'b0, ex_gpr_we_}, 32'd1);
    check("inv_mem",  {30'b0, ex_mem_op}, MEM_OP_NOP);

    // Valid load with every field live, then reset while stalled.
    drive_idle();
    id_en = 1'b1; id_pc = 30'h3; id_br_flag = 1'b1; id_mem_op = MEM_OP_LDW;
    id_ctrl_op = CTRL_OP_WRCR; id_dst_addr = 5'd7; id_gpr_we_ = ENABLE_;
    id_mem_wr_data = 32'h1234;
    drive_alu(ALU_OP_OR, 32'hA5, 32'h5A, 32'hFF);
    step();
    check_ex_out("or_out");
    check("or_mem",  {30'b0, ex_mem_op}, MEM_OP_LDW);
    check("or_ctrl", {30'b0, ex_ctrl_op}, CTRL_OP_WRCR);
    check("or_dst",  {27'b0, ex_dst_addr}, 32'd7);
    reset = 1'b1; stall = 1'b1;
    step();
    check_bubble("midreset");
    reset = 1'b0; stall = 1'b0;

    check("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the simple ARM pipeline, the consumer of the ID/EX pipeline register.
- Performs the ALU operation on id_alu_in_0 and id_alu_in_1, and detects signed overflow.
- Drives forwarding data back to the decode stage.
- Registers results into the EX/MEM pipeline register under stall and flush control.

Parameters:
- DATA_W, 32, datapath width
- PC_W, 30, word-address PC width
- REG_AW, 5, GPR address width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- stall  in  1  hold EX/MEM register
- flush  in  1  insert bubble into EX/MEM register
- int_detect  in  1  external interrupt pending
- id_pc  in  30  PC of instruction in ID/EX
- id_en  in  1  ID/EX entry valid
- id_alu_op  in  4  ALU operation
- id_alu_in_0  in  32  ALU operand 0
- id_alu_in_1  in  32  ALU operand 1
- id_br_flag  in  1  instruction is a branch
- id_mem_op  in  2  memory operation
- id_mem_wr_data  in  32  store data
- id_ctrl_op  in  2  control operation
- id_dst_addr  in  5  destination GPR
- id_gpr_we_  in  1  GPR write enable, active-low
- id_exp_code  in  3  exception code from decode
- fwd_data  out  32  combinational ALU result for ID-stage forwarding
- ex_pc  out  30  registered PC
- ex_en  out  1  EX/MEM entry valid
- ex_br_flag  out  1  registered branch flag
- ex_mem_op  out  2  registered memory op
- ex_mem_wr_data  out  32  registered store data
- ex_ctrl_op  out  2  registered control op
- ex_dst_addr  out  5  registered destination
- ex_gpr_we_  out  1  registered GPR write enable, active-low
- ex_exp_code  out  3  registered exception code
- ex_out  out  32  registered ALU result

Behaviour:
- Clocking: one clock, clk. reset is synchronous and active-high.
- ALU (combinational, fwd_data = alu_out), by op:
  - NOP(0): alu_in_0 passes through
  - AND(1), OR(2), XOR(3): bitwise
  - ADDS(4), ADDU(5): add
  - SUBS(6), SUBU(7): subtract
  - SHRL(8): logical right shift
  - SHLL(9): left shift
  - Codes 10-15: result 0
  - Add/sub results wrap modulo 2^32.
  - Shift amount is alu_in_1[4:0]; upper bits ignored.
- Overflow, raised only for ADDS/SUBS:
  - ADDS: operand signs equal and result sign differs.
  - SUBS: operand signs differ and result sign differs from alu_in_0.
  - ADDU/SUBU never raise overflow.
- Register update priority each posedge: reset > stall > flush > load.
- reset, and also the flush bubble:
  - ex_pc=0, ex_en=0, ex_br_flag=0
  - ex_mem_op=MEM_OP_NOP, ex_mem_wr_data=0, ex_ctrl_op=CTRL_OP_NOP
  - ex_dst_addr=0, ex_gpr_we_=1 (disabled)
  - ex_exp_code=ISA_EXP_NO_EXP, ex_out=0
- stall=1: all registers hold, including when flush=1 in the same cycle.
- load:
  - ex_en <= id_en
  - ex_pc, ex_br_flag, ex_mem_wr_data, ex_dst_addr and ex_out <= alu_out are captured.
- Exception resolution, only when id_en=1, in priority order:
  1. int_detect=1: ex_exp_code=EXT_INT.
  2. id_exp_code != NO_EXP: pass id_exp_code through.
  3. overflow: ex_exp_code=OVERFLOW.
  4. Otherwise NO_EXP.
- When any exception is resolved:
  - ex_mem_op=NOP, ex_ctrl_op=NOP, ex_gpr_we_=1.
  - ex_pc and ex_en are still captured.
- No exception: ex_mem_op, ex_ctrl_op and ex_gpr_we_ copy the id_* inputs.
- id_en=0 on load: ex_en=0, ex_gpr_we_=1, ex_mem_op=NOP, ex_ctrl_op=NOP, ex_exp_code=NO_EXP; other fields are captured (don't care).
- Latency: one cycle from ID/EX to EX/MEM; fwd_data has zero cycles of latency.

Decomposition:
- Shared package/header holds:
  - ALU op codes
  - MEM_OP_NOP/LDW/STW (0/1/2)
  - CTRL_OP_NOP/WRCR/EXRT (0/1/2)
  - ISA_EXP codes: NO_EXP 0, EXT_INT 1, UNDEF_INSN 2, OVERFLOW 3, MISS_ALIGN 4, TRAP 5, PRV_VIO 6
  - ENABLE_=0, DISABLE_=1
- Sub-modules: alu (combinational result + overflow) and ex_reg (EX/MEM register with exception gating).
- ex_stage only wires these two.

Test Plan:
- ADDU: 0xFFFFFFFF + 1, id_en=1 -> fwd_data=0 same cycle; next cycle ex_out=0, ex_exp_code=0, ex_gpr_we_ copies id_gpr_we_=0.
- ADDS: 0x7FFFFFFF + 1, id_gpr_we_=0, id_mem_op=STW -> ex_exp_code=3, ex_gpr_we_=1, ex_mem_op=0, ex_en=1.
- SHLL: in_0=1, in_1=0x00000024 -> ex_out=0x10 (shift amount 4).
- stall=1 with new inputs, then flush=1 with stall=1 -> outputs unchanged. Then flush=1 alone -> ex_en=0, ex_gpr_we_=1, ex_out=0.
- int_detect=1 with id_exp_code=UNDEF_INSN, id_en=1 -> ex_exp_code=1. Same stimulus with id_en=0 -> ex_exp_code=0.
- reset asserted mid-stream -> all outputs at reset values on the next posedge; stall is ignored while reset is high.
